// File: rtl/frigate_sar_pkg.sv
// Shared definitions for the frigate SAR ADC controller: FSM encoding, default sizes and clog2.
package frigate_sar_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSample = 2'd1,
    StConv   = 2'd2
  } sar_state_e;

  localparam int unsigned DefWidth = 12;
  localparam int unsigned DefNch   = 8;
  localparam int unsigned DefChw   = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/frigate_sar_bit_engine.sv
// Binary-search engine: one-hot trial bit walking MSB to LSB, kept-bit register, settle counter.
module frigate_sar_bit_engine
  import frigate_sar_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] trial_o,
  output logic [WIDTH-1:0] code_o,
  output logic             done_o
);

  localparam int unsigned SetW = (clog2(SETTLE_CYC + 1) > 0) ? clog2(SETTLE_CYC + 1) : 1;

  logic [WIDTH-1:0] bit_q;
  logic [WIDTH-1:0] kept_q;
  logic [SetW-1:0]  settle_q;
  logic             active_q;
  logic             done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_q    <= '0;
      kept_q   <= '0;
      settle_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        active_q <= 1'b0;
        bit_q    <= '0;
      end else if (go_i) begin
        bit_q    <= {1'b1, {(WIDTH-1){1'b0}}};
        kept_q   <= '0;
        settle_q <= '0;
        active_q <= 1'b1;
      end else if (active_q) begin
        // Comparator is only trusted on the last cycle of each trial.
        if (settle_q == SetW'(SETTLE_CYC)) begin
          settle_q <= '0;
          if (cmp_i) kept_q <= kept_q | bit_q;
          if (bit_q[0]) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
            bit_q    <= '0;
          end else begin
            bit_q <= bit_q >> 1;
          end
        end else begin
          settle_q <= settle_q + SetW'(1);
        end
      end
    end
  end

  assign trial_o = active_q ? (kept_q | bit_q) : '0;
  assign code_o  = kept_q;
  assign done_o  = done_q;

endmodule

// File: rtl/frigate_sar_adc_ctrl.sv
// SAR ADC controller: sample/convert sequencing, result valid/ready register, channel checks.
// Optional multi-channel scan when FRIGATE_SAR_SCAN_EN is defined.
module frigate_sar_adc_ctrl
  import frigate_sar_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned NCH        = DefNch,
  parameter int unsigned CHW        = DefChw,
  parameter int unsigned SAMPLE_CYC = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [CHW-1:0]   ch_sel_i,
`ifdef FRIGATE_SAR_SCAN_EN
  input  logic [NCH-1:0]   scan_mask_i,
  input  logic             scan_go_i,
`endif
  output logic             busy_o,
  output logic             ch_err_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic [CHW-1:0]   data_ch_o,
  output logic             adc_en_o,
  output logic             adc_rst_o,
  output logic             adc_hold_o,
  output logic [CHW-1:0]   adc_b_o,
  output logic [WIDTH-1:0] adc_data_o,
  input  logic             adc_cmp_i
);

  localparam int unsigned SmpW = (clog2(SAMPLE_CYC) > 0) ? clog2(SAMPLE_CYC) : 1;

  sar_state_e       state_q;
  logic [SmpW-1:0]  smp_cnt_q;
  logic             ch_err_q, data_valid_q, adc_en_q, adc_rst_q, adc_hold_q;
  logic [WIDTH-1:0] data_out_q;
  logic [CHW-1:0]   data_ch_q, adc_b_q;

  logic             eng_go, eng_done;
  logic [WIDTH-1:0] eng_code;
  logic             ch_ok, res_free, scan_run, start_acc, scan_acc, ch_err_cond;
  logic [CHW-1:0]   acc_ch;

  assign ch_ok    = 32'(ch_sel_i) < NCH;
  assign res_free = !data_valid_q || data_ready_i;

`ifdef FRIGATE_SAR_SCAN_EN
  logic [NCH-1:0] scan_pend_q;
  logic [NCH-1:0] scan_onehot;
  logic [CHW-1:0] scan_ch;

  assign scan_run    = |scan_pend_q;
  assign scan_onehot = scan_pend_q & (~scan_pend_q + {{(NCH-1){1'b0}}, 1'b1});

  always_comb begin
    scan_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (scan_pend_q[i]) scan_ch = CHW'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_pend_q <= '0;
    end else if (!en_i) begin
      scan_pend_q <= '0;
    end else if (state_q == StIdle) begin
      if (scan_acc) scan_pend_q <= scan_pend_q & ~scan_onehot;
      else if (!scan_run && scan_go_i) scan_pend_q <= scan_mask_i;
    end
  end

  assign start_acc   = start_i && en_i && ch_ok && res_free && !scan_run && !scan_go_i;
  assign scan_acc    = scan_run && en_i && res_free;
  assign ch_err_cond = start_i && en_i && !ch_ok && !scan_run && !scan_go_i;
  assign acc_ch      = scan_run ? scan_ch : ch_sel_i;
`else
  assign scan_run    = 1'b0;
  assign start_acc   = start_i && en_i && ch_ok && res_free;
  assign scan_acc    = 1'b0;
  assign ch_err_cond = start_i && en_i && !ch_ok;
  assign acc_ch      = ch_sel_i;
`endif

  // The engine starts on the same edge that enters CONV, so the MSB trial lines up with HOLD rising.
  assign eng_go = (state_q == StSample) && en_i && (smp_cnt_q == SmpW'(SAMPLE_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      smp_cnt_q    <= '0;
      ch_err_q     <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      data_ch_q    <= '0;
      adc_en_q     <= 1'b0;
      adc_rst_q    <= 1'b1;
      adc_hold_q   <= 1'b0;
      adc_b_q      <= '0;
    end else begin
      ch_err_q <= 1'b0;
      if (data_valid_q && data_ready_i) data_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_acc || scan_acc) begin
            state_q   <= StSample;
            smp_cnt_q <= '0;
            adc_en_q  <= 1'b1;
            adc_rst_q <= 1'b0;
            adc_b_q   <= acc_ch;
          end else if (ch_err_cond) begin
            ch_err_q <= 1'b1;
          end
        end
        StSample: begin
          if (!en_i) begin
            state_q   <= StIdle;
            adc_en_q  <= 1'b0;
            adc_rst_q <= 1'b1;
          end else if (eng_go) begin
            state_q    <= StConv;
            adc_hold_q <= 1'b1;
          end else begin
            smp_cnt_q <= smp_cnt_q + SmpW'(1);
          end
        end
        StConv: begin
          if (!en_i || eng_done) begin
            state_q    <= StIdle;
            adc_en_q   <= 1'b0;
            adc_rst_q  <= 1'b1;
            adc_hold_q <= 1'b0;
          end
          if (en_i && eng_done) begin
            data_out_q   <= eng_code;
            data_ch_q    <= adc_b_q;
            data_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  frigate_sar_bit_engine #(
    .WIDTH      (WIDTH),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_bit_engine (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .go_i    (eng_go),
    .abort_i (!en_i),
    .cmp_i   (adc_cmp_i),
    .trial_o (adc_data_o),
    .code_o  (eng_code),
    .done_o  (eng_done)
  );

  assign busy_o       = (state_q != StIdle);
  assign ch_err_o     = ch_err_q;
  assign data_valid_o = data_valid_q;
  assign data_out_o   = data_out_q;
  assign data_ch_o    = data_ch_q;
  assign adc_en_o     = adc_en_q;
  assign adc_rst_o    = adc_rst_q;
  assign adc_hold_o   = adc_hold_q;
  assign adc_b_o      = adc_b_q;

endmodule

// File: tb/tb_frigate_sar_adc_ctrl.sv
// Scoreboard bench for frigate_sar_adc_ctrl with a behavioural S/H + DAC + comparator model.
module tb_frigate_sar_adc_ctrl;

  localparam int W   = 12;
  localparam int NCH = 6;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en, start, data_ready, adc_cmp;
  logic [CHW-1:0] ch_sel;
  logic           busy, ch_err, data_valid, adc_en, adc_rst, adc_hold;
  logic [W-1:0]   data_out, adc_data;
  logic [CHW-1:0] data_ch, adc_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0]   code;
    logic [CHW-1:0] ch;
  } res_t;
  res_t exp_q[$];

  real vin [NCH];
  real held = 0.0;
  int  cmp_mode = 0;  // 0 analog model, 1 stuck high, 2 stuck low

  localparam logic [35:0] RstVec = {3'b000, 12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 12'h000};

  frigate_sar_adc_ctrl #(
    .WIDTH      (W),
    .NCH        (NCH),
    .CHW        (CHW),
    .SAMPLE_CYC (4),
    .SETTLE_CYC (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .start_i      (start),
    .ch_sel_i     (ch_sel),
`ifdef FRIGATE_SAR_SCAN_EN
    .scan_mask_i  ('0),
    .scan_go_i    (1'b0),
`endif
    .busy_o       (busy),
    .ch_err_o     (ch_err),
    .data_valid_o (data_valid),
    .data_ready_i (data_ready),
    .data_out_o   (data_out),
    .data_ch_o    (data_ch),
    .adc_en_o     (adc_en),
    .adc_rst_o    (adc_rst),
    .adc_hold_o   (adc_hold),
    .adc_b_o      (adc_b),
    .adc_data_o   (adc_data),
    .adc_cmp_i    (adc_cmp)
  );

  always #5 clk = ~clk;

  always @(posedge adc_hold) held = vin[adc_b];

  assign adc_cmp = (cmp_mode == 1) ? 1'b1 :
                   (cmp_mode == 2) ? 1'b0 :
                   (held > $itor(adc_data) * 3.3 / 4096.0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [35:0] outs();
    return {busy, ch_err, data_valid, data_out, data_ch, adc_en, adc_rst, adc_hold, adc_b, adc_data};
  endfunction

  // Monitor: a transfer happens on the edge after valid & ready is seen.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got code 0x%0h ch %0d with nothing expected",
                 data_out, data_ch);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("result", {data_out, data_ch}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [CHW-1:0] ch);
    start  = 1'b1;
    ch_sel = ch;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((busy || data_valid) && n < 200) begin
      tick();
      n++;
    end
    if (busy || data_valid) begin
      total++;
      bad++;
      $display("FAIL wait_quiet: busy=%0b valid=%0b after 200 cycles, required idle", busy, data_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] e;
    logic [W-1:0] codes [5];
    logic [CHW-1:0] chans [5];

    vin[0] = 1.0; vin[1] = 3.3; vin[2] = 0.0; vin[3] = 2.0; vin[4] = 1.2; vin[5] = 0.5;
    codes = '{12'h4D9, 12'hFFF, 12'h000, 12'h9B2, 12'h26C};
    chans = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    en = 1'b1; start = 1'b0; ch_sel = '0; data_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), RstVec);
    rst = 1'b0;
    tick();

    // Channel 0 at 1.0 V with latency measured from the accept edge
    exp_q.push_back({12'h4D9, 3'd0});
    issue(0);
    chk("sample_pins", {busy, adc_en, adc_rst, adc_hold, adc_b}, {1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
    n = 0;
    while (!data_valid && n < 60) begin
      tick();
      n++;
    end
    chk("latency", n, 29);
    wait_quiet();

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({codes[i], chans[i]});
      issue(chans[i]);
      wait_quiet();
    end

    // Start while busy is ignored
    exp_q.push_back({12'h4D9, 3'd0});
    issue(0);
    repeat (5) tick();
    issue(3);
    chk("busy_start_adc_b", {busy, adc_b}, {1'b1, 3'd0});
    wait_quiet();

    // Comparator stuck high: trial codes accumulate from the MSB
    cmp_mode = 1;
    exp_q.push_back({12'hFFF, 3'd4});
    issue(4);
    repeat (4) tick();
    for (int k = 0; k < W; k++) begin
      e = 12'hFFF << (11 - k);
      chk("trial_hi", adc_data, e);
      tick();
      tick();
    end
    wait_quiet();

    // Comparator stuck low: only the current trial bit is set
    cmp_mode = 2;
    exp_q.push_back({12'h000, 3'd4});
    issue(4);
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      e = 12'h001 << (11 - k);
      chk("trial_lo", adc_data, e);
      tick();
      tick();
    end
    wait_quiet();
    cmp_mode = 0;

    // Backpressure: pending result blocks new starts
    data_ready = 1'b0;
    exp_q.push_back({12'h4D9, 3'd0});
    issue(0);
    n = 0;
    while (!data_valid && n < 60) begin
      tick();
      n++;
    end
    chk("bp_valid", data_valid, 1);
    issue(2);
    chk("bp_busy", {busy, data_valid}, {1'b0, 1'b1});
    data_ready = 1'b1;
    exp_q.push_back({12'h000, 3'd2});
    issue(2);
    chk("bp_accept", busy, 1);
    wait_quiet();

    // en dropped on CONV cycle 10
    issue(0);
    repeat (13) tick();
    en = 1'b0;
    tick();
    chk("abort_pins", {busy, adc_en, adc_rst, adc_hold, adc_data},
        {1'b0, 1'b0, 1'b1, 1'b0, 12'h000});
    en = 1'b1;
    n = 0;
    repeat (35) begin
      tick();
      if (data_valid) n++;
    end
    chk("abort_no_result", n, 0);

    // Asynchronous reset mid-SAMPLE
    issue(1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_sample", outs(), RstVec);
    tick();
    rst = 1'b0;
    tick();

    // Out-of-range channels
    issue(7);
    chk("ch_err_pulse7", {ch_err, busy}, {1'b1, 1'b0});
    tick();
    chk("ch_err_clear", {ch_err, busy}, {1'b0, 1'b0});
    issue(6);
    chk("ch_err_pulse6", {ch_err, busy}, {1'b1, 1'b0});
    tick();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
